// File: rtl/tt_pin_pkg.sv
// tt_pin_pkg: shared types and pin-map constants for the Tiny Tapeout pin master.
//   tt_pin_state_t : master FSM states
//   UIO_*          : bit positions on the bidirectional uio bus
//   UIO_OE_MASK    : output-enable pattern (bits 6/7 are inputs)
package tt_pin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RESP    = 3'd4
  } tt_pin_state_t;

  localparam int unsigned UIO_ADDR_LSB = 0;
  localparam int unsigned UIO_STROBE   = 4;
  localparam int unsigned UIO_WRITE    = 5;
  localparam int unsigned UIO_ACK      = 6;

  localparam logic [7:0] UIO_OE_MASK = 8'h3F;

endpackage

// File: rtl/tt_sync.sv
// tt_sync: single-bit multi-flop synchronizer, async active-high reset to 0.
//   clk, rst : clock, asynchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output, lags d by STAGES edges
module tt_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/tt_pin_master.sv
// tt_pin_master: turns single read/write commands into a 4-phase strobe/ack
// handshake on the Tiny Tapeout pins and returns read data or a timeout flag.
//   cmd_*        : command channel (valid/ready), write flag, 4-bit addr, 8-bit wdata
//   rsp_*        : response channel (valid/ready), read data, timeout flag
//   pin_ui       : drives ui_in (write data)
//   pin_uio_out  : [3:0] addr, [4] strobe, [5] write, [7:6] zero
//   pin_uio_oe   : constant 0x3F
//   pin_uio_in   : bit 6 is the responder's ack
//   pin_uo       : responder read data, sampled while ack is high
// Build option: define TT_PIN_MASTER_TIMEOUT_EN to add the STROBE/RELEASE
// timeout counter and abort path.
module tt_pin_master
  import tt_pin_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_timeout,
  output logic [7:0] pin_ui,
  output logic [7:0] pin_uio_out,
  output logic [7:0] pin_uio_oe,
  input  logic [7:0] pin_uio_in,
  input  logic [7:0] pin_uo
);

  tt_pin_state_t state_q, state_d;
  logic       wr_q, wr_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [3:0] pin_addr_q, pin_addr_d;
  logic       pin_wr_q, pin_wr_d;
  logic       strobe_q, strobe_d;
  logic [7:0] pin_ui_q, pin_ui_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_timeout_q, rsp_timeout_d;
  logic       ack_s;
  logic       tmo_c;

  // Only the ack bit of the uio input bus is meaningful.
  logic unused_uio;
  assign unused_uio = ^{pin_uio_in[7], pin_uio_in[5:0]};

  tt_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (pin_uio_in[UIO_ACK]),
    .q   (ack_s)
  );

`ifdef TT_PIN_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  // Restart on every state change so STROBE and RELEASE each get a full budget.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == ST_STROBE || state_q == ST_RELEASE) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tmo_c = (state_q == ST_STROBE || state_q == ST_RELEASE) && (cnt_q == TMO_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = ^16'(TIMEOUT_CYCLES);
  assign tmo_c = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    pin_addr_d    = pin_addr_q;
    pin_wr_d      = pin_wr_q;
    pin_ui_d      = pin_ui_q;
    strobe_d      = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          wr_d          = cmd_write;
          addr_d        = cmd_addr;
          wdata_d       = cmd_wdata;
          rsp_rdata_d   = 8'h00;
          rsp_timeout_d = 1'b0;
          state_d       = ST_SETUP;
        end
      end
      ST_SETUP: begin
        pin_addr_d = addr_q;
        pin_wr_d   = wr_q;
        pin_ui_d   = wr_q ? wdata_q : 8'h00;
        state_d    = ST_STROBE;
      end
      ST_STROBE: begin
        if (ack_s) begin
          rsp_rdata_d = wr_q ? 8'h00 : pin_uo;
          state_d     = ST_RELEASE;
        end else if (tmo_c) begin
          rsp_rdata_d   = 8'h00;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else begin
          strobe_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (tmo_c) begin
          rsp_rdata_d   = 8'h00;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          pin_addr_d  = 4'h0;
          pin_wr_d    = 1'b0;
          pin_ui_d    = 8'h00;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A responder still holding ack blocks the next command.
    cmd_ready_d = (state_d == ST_IDLE) && !ack_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_q          <= 1'b0;
      addr_q        <= 4'h0;
      wdata_q       <= 8'h00;
      pin_addr_q    <= 4'h0;
      pin_wr_q      <= 1'b0;
      strobe_q      <= 1'b0;
      pin_ui_q      <= 8'h00;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 8'h00;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      pin_addr_q    <= pin_addr_d;
      pin_wr_q      <= pin_wr_d;
      strobe_q      <= strobe_d;
      pin_ui_q      <= pin_ui_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Pin bus assembly from registered fields.
  always_comb begin
    pin_uio_out                       = 8'h00;
    pin_uio_out[UIO_ADDR_LSB +: 4]    = pin_addr_q;
    pin_uio_out[UIO_STROBE]           = strobe_q;
    pin_uio_out[UIO_WRITE]            = pin_wr_q;
  end

  assign pin_uio_oe  = UIO_OE_MASK;
  assign pin_ui      = pin_ui_q;
  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_tt_pin_master.sv
// tb_tt_pin_master: directed bench for tt_pin_master with a response scoreboard.
// Responder model modes: 0 zero-delay ack, 1 ack one cycle after strobe,
// 2 never ack, 3 ack forced by the bench.
module tb_tt_pin_master;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic [7:0] pin_ui;
  logic [7:0] pin_uio_out;
  logic [7:0] pin_uio_oe;
  logic [7:0] pin_uio_in;
  logic [7:0] pin_uo;

  int         mode;
  logic       force_ack;
  logic       ack_reg;
  logic       ack;
  logic [7:0] uo_data;

  int         checks;
  int         errors;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;

  tt_pin_master #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .pin_ui      (pin_ui),
    .pin_uio_out (pin_uio_out),
    .pin_uio_oe  (pin_uio_oe),
    .pin_uio_in  (pin_uio_in),
    .pin_uo      (pin_uo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder model
  always @(posedge clk) ack_reg <= pin_uio_out[4];

  always_comb begin
    ack = 1'b0;
    case (mode)
      0:       ack = pin_uio_out[4];
      1:       ack = ack_reg;
      3:       ack = force_ack;
      default: ack = 1'b0;
    endcase
  end

  assign pin_uio_in = {1'b1, ack, 6'h2A};
  assign pin_uo     = ack ? uo_data : 8'hFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares every consumed response against the queue.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rdata 0x%0h timeout %0d want no response", rsp_rdata, rsp_timeout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rsp_rdata !== mon_exp[8:1] || rsp_timeout !== mon_exp[0]) begin
          errors++;
          $display("FAIL rsp_data: got rdata 0x%0h timeout %0d want rdata 0x%0h timeout %0d",
                   rsp_rdata, rsp_timeout, mon_exp[8:1], mon_exp[0]);
        end
      end
    end
  end

  // Issues one command, pushes its expected response and follows it until rsp_valid.
  // lat/rise/fall are edge counts after the accept edge.
  task automatic txn(input logic wr, input logic [3:0] a, input logic [7:0] d,
                     input logic [7:0] exp_rd, input logic exp_to, input logic [7:0] exp_ui,
                     output int lat, output int rise, output int fall);
    int n;
    int bad_pins;
    int bad_rdy;
    bad_pins  = 0;
    bad_rdy   = 0;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    exp_q.push_back({exp_rd, exp_to});
    lat  = 0;
    rise = -1;
    fall = -1;
    while (1) begin
      if (pin_uio_out[4] && rise < 0) rise = lat;
      if (!pin_uio_out[4] && rise >= 0 && fall < 0) fall = lat;
      if (rsp_valid) break;
      if (cmd_ready) bad_rdy++;
      if (lat >= 1 && (pin_uio_out[3:0] !== a || pin_uio_out[5] !== wr ||
                       pin_uio_out[7:6] !== 2'b00 || pin_ui !== exp_ui)) bad_pins++;
      if (lat >= 100) break;
      tick();
      lat++;
    end
    chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    chk("pins_held", bad_pins, 0);
    chk("cmd_ready_busy", bad_rdy, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat;
    int rise;
    int fall;
    int n;
    int bad;
    int bad_acc;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 4'h0;
    cmd_wdata = 8'h00;
    rsp_ready = 1'b1;
    mode      = 0;
    force_ack = 1'b0;
    uo_data   = 8'h00;

    // Reset state
    tick();
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h00);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_pin_ui", 32'(pin_ui), 32'h00);
    chk("rst_pin_uio_out", 32'(pin_uio_out), 32'h00);
    chk("rst_pin_uio_oe", 32'(pin_uio_oe), 32'h3F);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);
    chk("pin_uio_oe_run", 32'(pin_uio_oe), 32'h3F);

    // Write 0x3 <- 0xA5, ack one cycle after strobe
    mode = 1;
    txn(1'b1, 4'h3, 8'hA5, 8'h00, 1'b0, 8'hA5, lat, rise, fall);
    chk("wr_strobe_rise", rise, 2);
    chk("wr_strobe_fall", fall, 6);
    chk("wr_latency", lat, 10);
    tick();
    tick();
    chk("idle_uio_out", 32'(pin_uio_out), 32'h00);
    chk("idle_pin_ui", 32'(pin_ui), 32'h00);

    // Read 0xC, responder returns 0x5A; ui must stay 0 despite nonzero wdata
    uo_data = 8'h5A;
    txn(1'b0, 4'hC, 8'hFF, 8'h5A, 1'b0, 8'h00, lat, rise, fall);
    chk("rd_latency", lat, 10);

    // Zero-delay ack: rsp_valid 8 edges after accept
    mode    = 0;
    uo_data = 8'h96;
    txn(1'b0, 4'h6, 8'h00, 8'h96, 1'b0, 8'h00, lat, rise, fall);
    chk("zd_latency", lat, 8);
    chk("zd_strobe_rise", rise, 2);
    chk("zd_strobe_fall", fall, 5);
    tick();

    // Response backpressure: hold rsp_ready low for 5 cycles with a competing command
    rsp_ready = 1'b0;
    uo_data   = 8'h3C;
    txn(1'b0, 4'h5, 8'h00, 8'h3C, 1'b0, 8'h00, lat, rise, fall);
    bad     = 0;
    bad_acc = 0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 4'h1;
    cmd_wdata = 8'h11;
    repeat (5) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C || rsp_timeout !== 1'b0) bad++;
      if (cmd_ready !== 1'b0) bad_acc++;
    end
    chk("hold_rsp_stable", bad, 0);
    chk("hold_no_accept", bad_acc, 0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("hold_rsp_done", 32'(rsp_valid), 32'd0);

    // Reset during STROBE
    mode      = 2;
    cmd_write = 1'b0;
    cmd_addr  = 4'h7;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!pin_uio_out[4] && n < 20) begin
      tick();
      n++;
    end
    chk("strobe_before_rst", 32'(pin_uio_out[4]), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_strobe_async", 32'(pin_uio_out[4]), 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    n = 0;
    while (!cmd_ready && n < 10) begin
      tick();
      n++;
    end
    chk("ready_after_mid_rst", 32'(cmd_ready), 32'd1);
    repeat (12) tick();
    chk("rst_no_rsp", 32'(rsp_valid), 32'd0);

`ifdef TT_PIN_MASTER_TIMEOUT_EN
    // Timeout: responder never acks, then acks late
    mode      = 2;
    uo_data   = 8'h77;
    rsp_ready = 1'b0;
    txn(1'b0, 4'h9, 8'h00, 8'h00, 1'b1, 8'h00, lat, rise, fall);
    chk("tmo_strobe_rise", rise, 2);
    chk("tmo_strobe_fall", fall, 11);
    chk("tmo_latency", lat, 11);
    force_ack = 1'b1;
    mode      = 3;
    repeat (4) tick();
    chk("tmo_rsp_held", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    tick();
    bad = 0;
    repeat (5) begin
      if (cmd_ready !== 1'b0) bad++;
      tick();
    end
    chk("late_ack_blocks", bad, 0);
    force_ack = 1'b0;
    n = 0;
    while (!cmd_ready && n < 10) begin
      tick();
      n++;
    end
    chk("late_ack_release", 32'(cmd_ready), 32'd1);
    mode = 0;
`endif

    repeat (5) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
